key_pulse_sync: RTL and testbench

KEY_PULSE_SYNC -- requirements
Module: key_pulse_sync

---
 rtl/key_pulse_sync.sv | 126 ++++++++++++
 tb/tb_key_pulse_sync.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_pulse_sync.sv
// Debounced pushbutton front end: per-channel synchronizer and FSM
// producing press, release and long-press pulses plus a clean level.
module key_pulse_sync #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keyIn,
    output logic [NUM_KEYS-1:0] pressPulse,
    output logic [NUM_KEYS-1:0] releasePulse,
    output logic [NUM_KEYS-1:0] longPulse,
    output logic [NUM_KEYS-1:0] pressed
);

    localparam int MAX_CYC = (DEBOUNCE_CYCLES > LONG_CYCLES) ?
                             DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LG_LAST = CW'(LONG_CYCLES - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_PRESS_WAIT = 3'd1;
    localparam logic [2:0] S_DOWN       = 3'd2;
    localparam logic [2:0] S_DOWN_LONG  = 3'd3;
    localparam logic [2:0] S_REL_WAIT   = 3'd4;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        logic [1:0]    sync_q;
        logic          key_sync;
        logic [2:0]    st_q, st_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;
        logic          lvl_q, lvl_d;

        // Synchronizer idles high so a held key after reset reads as a new press
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= 2'b11;
            end else begin
                sync_q <= {sync_q[0], keyIn[g]};
            end
        end

        assign key_sync = sync_q[1];

        always_comb begin
            st_d    = st_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;
            unique case (st_q)
                S_IDLE: begin
                    if (!key_sync) st_d = S_PRESS_WAIT;
                end
                S_PRESS_WAIT: begin
                    if (key_sync) begin
                        st_d = S_IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        st_d    = S_DOWN;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DOWN: begin
                    if (key_sync) begin
                        st_d = S_REL_WAIT;
                    end else if (cnt_q == LG_LAST) begin
                        st_d   = S_DOWN_LONG;
                        long_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DOWN_LONG: begin
                    if (key_sync) st_d = S_REL_WAIT;
                end
                S_REL_WAIT: begin
                    // A bounce back low lands in DOWN_LONG so it cannot re-arm longPulse
                    if (!key_sync) begin
                        st_d = S_DOWN_LONG;
                    end else if (cnt_q == DB_LAST) begin
                        st_d  = S_IDLE;
                        rel_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: st_d = S_IDLE;
            endcase
            if (st_d != st_q) cnt_d = '0;
            lvl_d = (st_d == S_DOWN) || (st_d == S_DOWN_LONG) ||
                    (st_d == S_REL_WAIT);
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st_q    <= S_IDLE;
                cnt_q   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                lvl_q   <= 1'b0;
            end else begin
                st_q    <= st_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                lvl_q   <= lvl_d;
            end
        end

        assign pressPulse[g]   = press_q;
        assign releasePulse[g] = rel_q;
        assign longPulse[g]    = long_q;
        assign pressed[g]      = lvl_q;
    end

endmodule

// File: tb/tb_key_pulse_sync.sv
// Bench for key_pulse_sync: directed edge-exact checks plus random
// bouncing stimulus compared every cycle against a run-length model.
module tb_key_pulse_sync;

    localparam int NK = 2;
    localparam int D  = 4;
    localparam int L  = 10;

    logic          clk;
    logic          reset;
    logic [NK-1:0] keyIn;
    logic [NK-1:0] pressPulse;
    logic [NK-1:0] releasePulse;
    logic [NK-1:0] longPulse;
    logic [NK-1:0] pressed;

    int tests = 0;
    int fails = 0;

    key_pulse_sync #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keyIn       (keyIn),
        .pressPulse  (pressPulse),
        .releasePulse(releasePulse),
        .longPulse   (longPulse),
        .pressed     (pressed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [NK-1:0] act,
                       input logic [NK-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // Model: two-sample delay, then run lengths of stable samples
    bit            s1[NK], s2[NK];
    bit            m_pr[NK], m_armed[NK];
    int            m_run[NK], m_hold[NK];
    logic [NK-1:0] e_p, e_r, e_l, e_lv;

    function automatic void model_step(input logic [NK-1:0] kin,
                                       input logic rst);
        for (int i = 0; i < NK; i++) begin
            bit k;
            e_p[i] = 1'b0;
            e_r[i] = 1'b0;
            e_l[i] = 1'b0;
            if (!rst) begin
                s1[i] = 1'b1; s2[i] = 1'b1;
                m_pr[i] = 1'b0; m_armed[i] = 1'b0;
                m_run[i] = 0; m_hold[i] = 0;
            end else begin
                k = s2[i];
                s2[i] = s1[i];
                s1[i] = kin[i];
                if (!m_pr[i]) begin
                    if (!k) begin
                        m_run[i]++;
                        if (m_run[i] == D + 1) begin
                            e_p[i] = 1'b1;
                            m_pr[i] = 1'b1;
                            m_armed[i] = 1'b1;
                            m_hold[i] = 0;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end else begin
                    if (k) begin
                        m_armed[i] = 1'b0;
                        m_run[i]++;
                        if (m_run[i] == D + 1) begin
                            e_r[i] = 1'b1;
                            m_pr[i] = 1'b0;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                        if (m_armed[i]) begin
                            m_hold[i]++;
                            if (m_hold[i] == L) begin
                                e_l[i] = 1'b1;
                                m_armed[i] = 1'b0;
                            end
                        end
                    end
                end
            end
            e_lv[i] = m_pr[i];
        end
    endfunction

    always begin
        logic [NK-1:0] kin;
        logic          rin;
        @(posedge clk);
        kin = keyIn;
        rin = reset;
        model_step(kin, rin);
        #1;
        chk("model_press", pressPulse, e_p);
        chk("model_release", releasePulse, e_r);
        chk("model_long", longPulse, e_l);
        chk("model_pressed", pressed, e_lv);
    end

    initial begin
        int rem[NK];
        int rst_cnt;
        reset = 1'b0;
        keyIn = '1;
        repeat (3) @(negedge clk);
        chk("reset_press", pressPulse, '0);
        chk("reset_pressed", pressed, '0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press then long press
        keyIn[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            chk1("clean_press", pressPulse[0], k == 7);
            chk1("clean_pressed", pressed[0], k >= 7);
            chk1("long_once", longPulse[0], k == 17);
        end

        // Two-cycle release bounce while held
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            keyIn[0] = (k <= 2);
            @(posedge clk); #1;
            chk1("bounce_nolong", longPulse[0], 1'b0);
            chk1("bounce_norel", releasePulse[0], 1'b0);
            chk1("bounce_pressed", pressed[0], 1'b1);
        end

        // Clean release
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            keyIn[0] = 1'b1;
            @(posedge clk); #1;
            chk1("release_pulse", releasePulse[0], k == 7);
            chk1("release_pressed", pressed[0], k < 7);
        end

        // Press with one-cycle bounce; final fall is edge 5
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            keyIn[0] = (k == 4);
            @(posedge clk); #1;
            chk1("bounce_press", pressPulse[0], k == 11);
            chk1("bounce_press_lvl", pressed[0], k >= 11);
        end

        // Reset mid-hold with key still low
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_press", pressPulse, '0);
        chk("rst_release", releasePulse, '0);
        chk("rst_long", longPulse, '0);
        chk("rst_pressed", pressed, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk1("rst_repress", pressPulse[0], k == 7);
        end
        @(negedge clk);
        keyIn = '1;
        repeat (12) @(negedge clk);

        // Two channels two cycles apart
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) keyIn[0] = 1'b0;
            if (k == 3) keyIn[1] = 1'b0;
            @(posedge clk); #1;
            chk1("dual_press0", pressPulse[0], k == 7);
            chk1("dual_press1", pressPulse[1], k == 9);
        end
        @(negedge clk);
        keyIn = '1;
        repeat (12) @(negedge clk);

        // Random bouncing levels with occasional reset
        rst_cnt = 0;
        for (int i = 0; i < NK; i++) rem[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NK; i++) begin
                if (rem[i] == 0) begin
                    keyIn[i] = ~keyIn[i];
                    if ($urandom_range(0, 3) == 0)
                        rem[i] = $urandom_range(15, 40);
                    else
                        rem[i] = $urandom_range(1, 7);
                end else begin
                    rem[i]--;
                end
            end
            if (rst_cnt > 0) begin
                reset = 1'b0;
                rst_cnt--;
            end else begin
                reset = 1'b1;
                if ($urandom_range(0, 399) == 0) rst_cnt = 2;
            end
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
